// File: rtl/gshare_bp_ckpt_if.sv
// Fetch/execute side bundle for the gshare predictor.
//   master : fetch + branch unit (drives lookups and resolutions)
//   slave  : predictor (returns prediction, checkpoint and mispredict flag)
// Signals:
//   predF_valid/stallF/pcF             fetch-side lookup request
//   pred_takeF/pred_idxF/pred_ghrF     prediction plus idx/ghr checkpoint for E
//   updE_valid/idx/ghr/pred/actual     resolution from E
//   mispredE                           combinational mispredict flag
interface gshare_bp_ckpt_if #(
    parameter int GHR_W = 10,
    parameter int IDX_W = 10
);
    logic             predF_valid;
    logic             stallF;
    logic [31:0]      pcF;
    logic             pred_takeF;
    logic [IDX_W-1:0] pred_idxF;
    logic [GHR_W-1:0] pred_ghrF;
    logic             updE_valid;
    logic [IDX_W-1:0] updE_idx;
    logic [GHR_W-1:0] updE_ghr;
    logic             updE_pred;
    logic             updE_actual;
    logic             mispredE;

    modport master (
        output predF_valid, stallF, pcF,
        output updE_valid, updE_idx, updE_ghr, updE_pred, updE_actual,
        input  pred_takeF, pred_idxF, pred_ghrF, mispredE
    );

    modport slave (
        input  predF_valid, stallF, pcF,
        input  updE_valid, updE_idx, updE_ghr, updE_pred, updE_actual,
        output pred_takeF, pred_idxF, pred_ghrF, mispredE
    );
endinterface

// File: rtl/gshare_bp_ckpt.sv
// gshare direction predictor with speculative GHR and checkpoint repair.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   init_req       restart the PHT clear walk and zero the GHR
//   ready          1 while in RUN (predictions valid)
//   bp             fetch/execute bundle (slave side)
//   perf_clr       synchronous clear of the perf counters
//   perf_branches  resolved branch count (saturating)
//   perf_mispred   mispredict count (saturating)
//
// state  | meaning
// S_INIT | PHT clear walk, one entry per cycle; GHR frozen, updates ignored
// S_RUN  | predicting at F, training at E
module gshare_bp_ckpt #(
    parameter int         GHR_W    = 10,
    parameter int         IDX_W    = 10,
    parameter int         PC_LSB   = 2,
    parameter logic [1:0] INIT_CNT = 2'b10,
    parameter int         PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              ready,
    gshare_bp_ckpt_if.slave   bp,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispred
);
    localparam int               PHT_DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX  = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  init_ptr_q, init_ptr_d;
    logic [GHR_W-1:0]  ghr_q, ghr_d;
    logic              ready_q, ready_d;
    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_mp_q, perf_mp_d;

    logic [1:0]        pht [PHT_DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              pred_take;
    logic              mispred;
    logic              run;
    logic [1:0]        upd_cur, upd_nxt;
    logic [GHR_W-1:0]  spec_shift, repair_shift;
    logic              unused_pc;

    assign unused_pc = ^bp.pcF;
    assign run       = (state_q == S_RUN);
    assign idx       = bp.pcF[PC_LSB+IDX_W-1:PC_LSB] ^ IDX_W'(ghr_q);
    assign pred_take = ready_q & pht[idx][1];
    assign mispred   = bp.updE_valid & (bp.updE_pred != bp.updE_actual);

    assign bp.pred_takeF = pred_take;
    assign bp.pred_idxF  = idx;
    assign bp.pred_ghrF  = ghr_q;
    assign bp.mispredE   = mispred;

    assign ready         = ready_q;
    assign perf_branches = perf_br_q;
    assign perf_mispred  = perf_mp_q;

    // A 1-bit history keeps only the newest outcome.
    generate
        if (GHR_W == 1) begin : g_ghr1
            assign spec_shift   = pred_take;
            assign repair_shift = bp.updE_actual;
        end else begin : g_ghrn
            assign spec_shift   = {ghr_q[GHR_W-2:0], pred_take};
            assign repair_shift = {bp.updE_ghr[GHR_W-2:0], bp.updE_actual};
        end
    endgenerate

    always_comb begin
        upd_cur = pht[bp.updE_idx];
        upd_nxt = upd_cur;
        if (bp.updE_actual) begin
            if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'b01;
        end else begin
            if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'b01;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        ghr_d      = ghr_q;
        ready_d    = ready_q;
        perf_br_d  = perf_br_q;
        perf_mp_d  = perf_mp_q;

        if (init_req) begin
            state_d    = S_INIT;
            init_ptr_d = '0;
            ghr_d      = '0;
            ready_d    = 1'b0;
        end else if (!run) begin
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == LAST_IDX) begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
        end else if (mispred) begin
            // Repair wins over any same-cycle speculative shift.
            ghr_d = repair_shift;
        end else if (bp.predF_valid && !bp.stallF) begin
            ghr_d = spec_shift;
        end

        if (perf_clr) begin
            perf_br_d = '0;
            perf_mp_d = '0;
        end else if (run && bp.updE_valid) begin
            if (perf_br_q != '1) perf_br_d = perf_br_q + 1'b1;
            if (mispred && (perf_mp_q != '1)) perf_mp_d = perf_mp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_INIT;
            init_ptr_q <= '0;
            ghr_q      <= '0;
            ready_q    <= 1'b0;
            perf_br_q  <= '0;
            perf_mp_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ghr_q      <= ghr_d;
            ready_q    <= ready_d;
            perf_br_q  <= perf_br_d;
            perf_mp_q  <= perf_mp_d;
        end
    end

    // PHT has no reset; it is cleared by the INIT walk.
    always_ff @(posedge clk) begin
        if (!run) begin
            pht[init_ptr_q] <= INIT_CNT;
        end else if (bp.updE_valid) begin
            pht[bp.updE_idx] <= upd_nxt;
        end
    end
endmodule

// File: tb/tb_gshare_bp_ckpt.sv
module tb_gshare_bp_ckpt;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init_req = 1'b0;
    logic       perf_clr = 1'b0;
    logic       ready;
    logic [3:0] perf_branches;
    logic [3:0] perf_mispred;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cnt;

    gshare_bp_ckpt_if #(.GHR_W(3), .IDX_W(4)) bp ();

    gshare_bp_ckpt #(
        .GHR_W(3), .IDX_W(4), .PC_LSB(2), .INIT_CNT(2'b10), .PERF_W(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .init_req      (init_req),
        .ready         (ready),
        .bp            (bp.slave),
        .perf_clr      (perf_clr),
        .perf_branches (perf_branches),
        .perf_mispred  (perf_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_upd(input logic v, input logic [3:0] idx, input logic [2:0] ghr,
                           input logic pred, input logic act);
        bp.updE_valid  = v;
        bp.updE_idx    = idx;
        bp.updE_ghr    = ghr;
        bp.updE_pred   = pred;
        bp.updE_actual = act;
    endtask

    task automatic upd(input logic [3:0] idx, input logic [2:0] ghr,
                       input logic pred, input logic act);
        set_upd(1'b1, idx, ghr, pred, act);
        step();
        set_upd(1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic wait_ready(input string tag);
        cnt = 0;
        while (!ready && cnt < 40) begin
            step();
            cnt++;
        end
        chk(tag, cnt, 16);
    endtask

    initial begin
        bp.predF_valid = 1'b0;
        bp.stallF      = 1'b0;
        bp.pcF         = 32'h0;
        set_upd(1'b0, 4'd0, 3'd0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_take", bp.pred_takeF, 0);
        chk("rst_ghr", bp.pred_ghrF, 0);
        chk("rst_br", perf_branches, 0);
        chk("rst_mp", perf_mispred, 0);
        rst = 1'b1;
        wait_ready("init_cycles");

        for (int i = 0; i < 16; i++) begin
            bp.pcF = 32'(i) << 2;
            #1;
            chk($sformatf("pht_init_%0d", i), bp.pred_takeF, 1);
        end

        // Stalled fetch must not shift; unstalled taken shifts a 1 in.
        bp.pcF = 32'h10; bp.predF_valid = 1'b1; bp.stallF = 1'b1;
        #1;
        chk("idx_0x10", bp.pred_idxF, 4);
        chk("ghr_ckpt0", bp.pred_ghrF, 0);
        step();
        chk("stall_ghr", bp.pred_ghrF, 0);
        bp.stallF = 1'b0;
        step();
        bp.predF_valid = 1'b0;
        chk("shift_ghr", bp.pred_ghrF, 1);
        chk("idx_ghr1", bp.pred_idxF, 5);

        // ghr=1: pcF=0x14 -> idx 4.  Counter walk 10->01->00->00->01->10->11->11.
        bp.pcF = 32'h14;
        set_upd(1'b1, 4'd4, 3'd0, 1'b0, 1'b0);
        #1;
        chk("collide_old", bp.pred_takeF, 1);
        chk("no_misp", bp.mispredE, 0);
        step();
        set_upd(1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
        chk("nt1", bp.pred_takeF, 0);
        upd(4'd4, 3'd0, 1'b0, 1'b0); chk("nt2", bp.pred_takeF, 0);
        upd(4'd4, 3'd0, 1'b0, 1'b0); chk("nt3_sat", bp.pred_takeF, 0);
        upd(4'd4, 3'd0, 1'b1, 1'b1); chk("t1", bp.pred_takeF, 0);
        upd(4'd4, 3'd0, 1'b1, 1'b1); chk("t2", bp.pred_takeF, 1);
        upd(4'd4, 3'd0, 1'b1, 1'b1); chk("t3", bp.pred_takeF, 1);
        upd(4'd4, 3'd0, 1'b1, 1'b1); chk("t4_sat", bp.pred_takeF, 1);
        chk("br7", perf_branches, 7);
        chk("mp0", perf_mispred, 0);
        chk("ghr_hold", bp.pred_ghrF, 1);

        // Build ghr=111, then repair with checkpoint 101 + actual 1 -> 011.
        bp.predF_valid = 1'b1;
        step(); chk("ghr3", bp.pred_ghrF, 3);
        step(); chk("ghr7", bp.pred_ghrF, 7);
        set_upd(1'b1, 4'd4, 3'b101, 1'b0, 1'b1);
        #1;
        chk("misp_comb", bp.mispredE, 1);
        step();
        set_upd(1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
        bp.predF_valid = 1'b0;
        chk("repair_ghr", bp.pred_ghrF, 3);
        chk("br8", perf_branches, 8);
        chk("mp1", perf_mispred, 1);

        for (int i = 0; i < 15; i++) upd(4'd4, 3'b101, 1'b0, 1'b1);
        chk("mp_sat", perf_mispred, 15);
        chk("br_sat", perf_branches, 15);
        perf_clr = 1'b1;
        upd(4'd4, 3'b101, 1'b0, 1'b1);
        perf_clr = 1'b0;
        chk("clr_br", perf_branches, 0);
        chk("clr_mp", perf_mispred, 0);

        // Drive entry 7 to 00; ghr=011 so pcF=0x10 -> idx 7.
        upd(4'd7, 3'd0, 1'b0, 1'b0);
        upd(4'd7, 3'd0, 1'b0, 1'b0);
        bp.pcF = 32'h10;
        #1;
        chk("e7_cold", bp.pred_takeF, 0);
        chk("br2", perf_branches, 2);
        chk("mp0b", perf_mispred, 0);

        init_req = 1'b1;
        step();
        init_req = 1'b0;
        chk("ireq_ready", ready, 0);
        chk("ireq_ghr", bp.pred_ghrF, 0);
        chk("ireq_take", bp.pred_takeF, 0);

        // Resolution during INIT: flagged but ignored.
        set_upd(1'b1, 4'd7, 3'b111, 1'b0, 1'b1);
        #1;
        chk("init_misp", bp.mispredE, 1);
        step();
        set_upd(1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
        chk("init_ghr", bp.pred_ghrF, 0);
        chk("init_br", perf_branches, 2);
        chk("init_mp", perf_mispred, 0);
        repeat (4) step();
        chk("ptr5_ready", ready, 0);

        init_req = 1'b1;
        step();
        init_req = 1'b0;
        wait_ready("restart_cycles");
        chk("rdy_ghr", bp.pred_ghrF, 0);
        bp.pcF = 32'h1C;
        #1;
        chk("e7_reinit", bp.pred_takeF, 1);
        chk("keep_br", perf_branches, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
